// File: rtl/dff_pipe_pkg.sv
// rtl/dff_pipe_pkg.sv - shared types, defaults and helpers for the dff_pipe delay pipeline
package dff_pipe_pkg;

  localparam int DFLT_WIDTH = 8;
  localparam int DFLT_DEPTH = 3;

  // Stage record at the default width; the stages themselves are width-parametrised
  typedef struct packed {
    logic [DFLT_WIDTH-1:0] data;
    logic [DFLT_WIDTH-1:0] data_n;
    logic                  valid;
  } stage_t;

  function automatic int clog2_occ(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// rtl/dff_pipe_if.sv - producer/consumer handshake bundle for dff_pipe
interface dff_pipe_if
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFLT_WIDTH
);

  logic             Flush;
  logic [WIDTH-1:0] In_data;
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Out_data;
  logic [WIDTH-1:0] Out_data_n;
  logic             Out_valid;
  logic             Out_ready;

  modport master (
    output Flush, In_data, In_valid, Out_ready,
    input  In_ready, Out_data, Out_data_n, Out_valid
  );

  modport slave (
    input  Flush, In_data, In_valid, Out_ready,
    output In_ready, Out_data, Out_data_n, Out_valid
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one register stage: async reset, flush, bubble-collapsing ready
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DFLT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter bit               CLK_NEG = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  input  logic             dn_ready,
  output logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_n,
  output logic             valid
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_n_d;
  logic             valid_d;

  assign ready = ~valid | dn_ready;

  always_comb begin
    data_d   = data;
    data_n_d = data_n;
    valid_d  = valid;
    if (Flush) begin
      data_d   = RST_VAL;
      data_n_d = ~RST_VAL;
      valid_d  = 1'b0;
    end else if (ready) begin
      data_d   = up_data;
      data_n_d = ~up_data;
      valid_d  = up_valid;
    end
  end

  generate
    if (CLK_NEG) begin : g_neg
      always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
          data   <= RST_VAL;
          data_n <= ~RST_VAL;
          valid  <= 1'b0;
        end else begin
          data   <= data_d;
          data_n <= data_n_d;
          valid  <= valid_d;
        end
      end
    end else begin : g_pos
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          data   <= RST_VAL;
          data_n <= ~RST_VAL;
          valid  <= 1'b0;
        end else begin
          data   <= data_d;
          data_n <= data_n_d;
          valid  <= valid_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - DEPTH-stage valid/ready register pipeline with registered complement output
// Optional Occupancy output when DFF_PIPE_OCC_EN is defined.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DFLT_WIDTH,
  parameter int               DEPTH   = DFLT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter bit               CLK_NEG = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
`ifdef DFF_PIPE_OCC_EN
  output logic [clog2_occ(DEPTH)-1:0] Occupancy,
`endif
  dff_pipe_if.slave bus
);

  // Index i is the upstream of stage i; index DEPTH is the pipe output
  logic [WIDTH-1:0] chain_data  [DEPTH+1];
  logic             chain_valid [DEPTH+1];
  logic             chain_ready [DEPTH+1];
  logic [WIDTH-1:0] stage_data_n [DEPTH];

  assign chain_data[0]      = bus.In_data;
  assign chain_valid[0]     = bus.In_valid;
  assign chain_ready[DEPTH] = bus.Out_ready;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      dff_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .CLK_NEG (CLK_NEG)
      ) u_stage (
        .Clk      (Clk),
        .Rst      (Rst),
        .Flush    (bus.Flush),
        .up_data  (chain_data[i]),
        .up_valid (chain_valid[i]),
        .dn_ready (chain_ready[i+1]),
        .ready    (chain_ready[i]),
        .data     (chain_data[i+1]),
        .data_n   (stage_data_n[i]),
        .valid    (chain_valid[i+1])
      );
    end
  endgenerate

  assign bus.In_ready   = chain_ready[0] & ~bus.Flush;
  assign bus.Out_data   = chain_data[DEPTH];
  assign bus.Out_data_n = stage_data_n[DEPTH-1];
  assign bus.Out_valid  = chain_valid[DEPTH];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCC_W = clog2_occ(DEPTH);

  logic [OCC_W-1:0] occ_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = bus.In_valid & bus.In_ready;
  assign out_xfer = bus.Out_valid & bus.Out_ready;

  // Valid words are conserved inside the chain, so only the two ends move the count
  always_comb begin
    occ_d = Occupancy;
    if (bus.Flush) begin
      occ_d = '0;
    end else begin
      occ_d = Occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  generate
    if (CLK_NEG) begin : g_occ_neg
      always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) Occupancy <= '0;
        else     Occupancy <= occ_d;
      end
    end else begin : g_occ_pos
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) Occupancy <= '0;
        else     Occupancy <= occ_d;
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - randomized self-checking bench for dff_pipe (negedge/00 and posedge/A5 builds)
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam int D = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] st_data   = 8'h00;
  logic       st_valid  = 1'b0;
  logic       st_oready = 1'b1;
  logic       st_flush  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  always #5 Clk = ~Clk;

  dff_pipe_if #(.WIDTH(8)) bus_n ();
  dff_pipe_if #(.WIDTH(8)) bus_p ();

  assign bus_n.In_data   = st_data;
  assign bus_n.In_valid  = st_valid;
  assign bus_n.Out_ready = st_oready;
  assign bus_n.Flush     = st_flush;
  assign bus_p.In_data   = st_data;
  assign bus_p.In_valid  = st_valid;
  assign bus_p.Out_ready = st_oready;
  assign bus_p.Flush     = st_flush;

`ifdef DFF_PIPE_OCC_EN
  logic [1:0] occ_n;
  logic [1:0] occ_p;
`endif

  dff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'h00), .CLK_NEG(1'b1)) dut_n (
    .Clk       (Clk),
    .Rst       (Rst),
`ifdef DFF_PIPE_OCC_EN
    .Occupancy (occ_n),
`endif
    .bus       (bus_n)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'hA5), .CLK_NEG(1'b0)) dut_p (
    .Clk       (Clk),
    .Rst       (Rst),
`ifdef DFF_PIPE_OCC_EN
    .Occupancy (occ_p),
`endif
    .bus       (bus_p)
  );

  stage_t obs;
  logic   obs_in_ready;
  always_comb begin
    if (sel == 0) begin
      obs.data     = bus_n.Out_data;
      obs.data_n   = bus_n.Out_data_n;
      obs.valid    = bus_n.Out_valid;
      obs_in_ready = bus_n.In_ready;
    end else begin
      obs.data     = bus_p.Out_data;
      obs.data_n   = bus_p.Out_data_n;
      obs.valid    = bus_p.Out_valid;
      obs_in_ready = bus_p.In_ready;
    end
  end

  // Reference: ordered list of words in flight, each tagged with its stage position
  typedef struct {
    logic [7:0] d;
    int         pos;
  } ent_t;

  ent_t       q[$];
  logic [7:0] rv = 8'h00;
  bit         rst_data_known = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void advance(input bit ordy);
    if (q.size() > 0 && q[0].pos == D-1 && ordy) q.delete(0);
    for (int i = 0; i < q.size(); i++) begin
      int lim = (i == 0) ? D-1 : q[i-1].pos - 1;
      if (q[i].pos < lim) q[i].pos++;
    end
  endfunction

  function automatic bit slot0_free_after(input bit ordy);
    ent_t save[$];
    bit   free;
    save = q;
    advance(ordy);
    free = (q.size() == 0) || (q[q.size()-1].pos > 0);
    q = save;
    return free;
  endfunction

  task automatic wait_drive();
    if (sel == 0) @(posedge Clk); else @(negedge Clk);
  endtask

  task automatic wait_active();
    if (sel == 0) @(negedge Clk); else @(posedge Clk);
  endtask

  task automatic check_occ();
`ifdef DFF_PIPE_OCC_EN
    check_val("occupancy", (sel == 0) ? occ_n : occ_p, q.size());
`endif
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit ordy, input bit fl, output bit acc);
    bit         exp_rdy;
    bit         exp_ov;
    logic [7:0] inv;
    ent_t       e;
    wait_drive();
    st_valid = v; st_data = d; st_oready = ordy; st_flush = fl;
    #1;
    exp_ov  = (q.size() > 0) && (q[0].pos == D-1);
    exp_rdy = !fl && slot0_free_after(ordy);
    check_val("in_ready", obs_in_ready, exp_rdy);
    check_val("out_valid", obs.valid, exp_ov);
    if (exp_ov) check_val("out_data", obs.data, q[0].d);
    else if (rst_data_known) check_val("out_data_rstval", obs.data, rv);
    inv = ~obs.data;
    check_val("out_data_n", obs.data_n, inv);
    check_occ();
    acc = v && exp_rdy;
    wait_active();
    if (fl) begin
      q.delete();
    end else begin
      advance(ordy);
      if (acc) begin
        e.d = d; e.pos = 0;
        q.push_back(e);
      end
    end
    rst_data_known = fl;
  endtask

  task automatic rst_pulse();
    logic [7:0] inv;
    wait_drive();
    st_valid = 1'b0; st_flush = 1'b0; st_oready = 1'b1;
    #2 Rst = 1'b1;
    #1;
    inv = ~rv;
    check_val("rst_out_valid", obs.valid, 1'b0);
    check_val("rst_out_data", obs.data, rv);
    check_val("rst_out_data_n", obs.data_n, inv);
    check_val("rst_in_ready", obs_in_ready, 1'b1);
    q.delete();
    check_occ();
    #1 Rst = 1'b0;
    wait_active();
    rst_data_known = 1'b1;
  endtask

  task automatic random_run(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0, acc);
  endtask

  initial begin
    bit         acc;
    int         idx;
    logic [7:0] words [5];

    // Power-up reset, CLK_NEG=1 / RST_VAL=00 build
    #12;
    check_val("por_out_valid", obs.valid, 1'b0);
    check_val("por_out_data", obs.data, 8'h00);
    check_val("por_out_data_n", obs.data_n, 8'hFF);
    check_val("por_in_ready", obs_in_ready, 1'b1);
    #12 Rst = 1'b0;

    // Back-to-back stream
    cycle(1, 8'h11, 1, 0, acc);
    cycle(1, 8'h22, 1, 0, acc);
    cycle(1, 8'h33, 1, 0, acc);
    cycle(1, 8'h44, 1, 0, acc);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, acc);

    // Backpressure: producer retries until each of 5 words is taken
    words = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    idx = 0;
    for (int i = 0; i < 30 && idx < 5; i++) begin
      cycle(1, words[idx], (i >= 6), 0, acc);
      if (acc) idx++;
    end
    check_val("backpressure_all_accepted", idx, 5);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0, acc);

    // Bubble collapse under stall
    cycle(1, 8'hA1, 0, 0, acc);
    cycle(0, 8'hEE, 0, 0, acc);
    cycle(1, 8'hA3, 0, 0, acc);
    cycle(0, 8'h00, 0, 0, acc);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, acc);

    // Flush with two words in flight and input presented
    cycle(1, 8'hC1, 0, 0, acc);
    cycle(1, 8'hC2, 0, 0, acc);
    cycle(1, 8'hC3, 1, 1, acc);
    cycle(1, 8'hC4, 1, 0, acc);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, acc);

    // Asynchronous reset mid-stream
    cycle(1, 8'hD1, 1, 0, acc);
    cycle(1, 8'hD2, 1, 0, acc);
    rst_pulse();
    random_run(300);

    // CLK_NEG=0 / RST_VAL=A5 build
    sel = 1;
    rv  = 8'hA5;
    q.delete();
    rst_pulse();
    cycle(1, 8'h3C, 1, 0, acc);
    cycle(1, 8'h4D, 1, 0, acc);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, acc);
    random_run(150);
    cycle(1, 8'h77, 0, 1, acc);
    cycle(0, 8'h00, 1, 0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit async-reset D flip-flop.
- DEPTH-stage, WIDTH-bit registered pipeline with a valid/ready handshake per stage, bubble collapsing, selectable active clock edge, a programmable reset value and a complemented output (Qbar equivalent).
- Used as a timing-retiming or delay element between producer/consumer blocks.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 3: number of register stages (>=1).
- RST_VAL, {WIDTH{1'b0}}: data value loaded into every stage on reset and flush.
- CLK_NEG, 1: 1 = stages update on negedge Clk; 0 = posedge Clk.

Ports:
- Clk  in  1  stage clock; edge selected by CLK_NEG.
- Rst  in  1  reset, asynchronous, active-high.
- Flush  in  1  synchronous clear of all stages.
- In_data  in  WIDTH  input data.
- In_valid  in  1  input data valid.
- In_ready  out  1  pipeline can accept In_data this edge.
- Out_data  out  WIDTH  last-stage data (Q).
- Out_data_n  out  WIDTH  bitwise complement of Out_data (Qbar), registered alongside it.
- Out_valid  out  1  last-stage valid.
- Out_ready  in  1  consumer accepts Out_data this edge.

Behaviour:
- Reset:
  - Rst high immediately forces every stage: data = RST_VAL, data_n = ~RST_VAL, valid = 0. Outputs therefore read Out_data = RST_VAL, Out_data_n = ~RST_VAL, Out_valid = 0.
  - Rst asserted mid-transfer discards all in-flight data; no handshake completes on that edge.
  - Release is synchronous to the next active edge.
- Stage i (0 = input side, DEPTH-1 = output side) holds data_i, data_n_i, valid_i. Define ready_DEPTH = Out_ready.
  - ready_i = ~valid_i | ready_(i+1). This is combinational bubble collapsing, so an empty stage always accepts.
  - On the active edge, if ready_i: data_i <= upstream data, data_n_i <= ~upstream data, valid_i <= upstream valid. The upstream of stage 0 is In_data/In_valid.
  - Otherwise the stage holds.
- In_ready = ready_0 & ~Flush.
  - Transfer at input: In_valid & In_ready.
  - Transfer at output: Out_valid & Out_ready.
- Latency: DEPTH active edges from input transfer to Out_valid, when the pipeline is empty and Out_ready = 1.
- Throughput: one word per edge while Out_ready = 1.
- Out_ready = 0 with all stages valid: In_ready = 0; all contents held unchanged and no data lost.
- Stall with bubbles: upstream words advance into empty stages until the pipe is full.
- Order preserved; no word is duplicated or dropped.
- Flush = 1 on an active edge:
  - All valid_i <= 0 and data <= RST_VAL; the input is not accepted (In_ready low).
  - An Out_valid & Out_ready on that edge still counts as consumed.
  - Flush overrides all simultaneous events except Rst.
- In_valid = 0 inserts a bubble (valid = 0). Data is still captured but ignored downstream.
- Out_data_n is registered, not derived combinationally. It must equal ~Out_data at all times after reset.
- CLK_NEG selects the sensitivity edge for all stages via generate. Handshake inputs are sampled on that same edge.

Optional Feature:
- Macro DFF_PIPE_OCC_EN.
- Defined:
  - Adds output Occupancy, width $clog2(DEPTH+1), giving the number of stages with valid = 1.
  - Registered, updated on the active edge, reset/flush to 0.
  - Range 0..DEPTH, never wraps.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package dff_pipe_pkg holds:
  - stage-state struct typedef (data, data_n, valid);
  - occupancy width function clog2_occ(DEPTH);
  - localparam defaults for WIDTH/DEPTH.
- One sub-module, dff_pipe_stage: a single stage with async reset, flush, ready_i computation and edge selection. The top generates DEPTH instances and chains the ready/valid signals.

Test Plan (WIDTH=8, DEPTH=3, RST_VAL=8'h00, CLK_NEG=1 unless noted):
- Rst=1 for 25 ns then 0, Out_ready=1 -> during reset Out_data=00, Out_data_n=FF, Out_valid=0, In_ready=1.
- Stream 11,22,33,44 on consecutive edges, Out_ready=1 -> Out_valid first high 3 edges after 11 accepted; outputs 11,22,33,44 in order on consecutive edges, Out_data_n = EE,DD,CC,BB.
- Out_ready=0, push 5 words -> pipe holds 3 words, In_ready=0 after 3rd accept, Out_data=first word stable. Out_ready=1 -> all 3 drained in order, then 4th/5th accepted and delivered.
- In_valid pattern 1,0,1 with Out_ready=0 -> bubble collapses: after 3 edges stages hold 2 valid words, In_ready still 1 (one slot free).
- Flush asserted with 2 words in flight and In_valid=1 -> next edge Out_valid=0, Out_data=00, In_ready=0 during Flush. Occupancy=0 if DFF_PIPE_OCC_EN.
- Rst pulsed asynchronously mid-stream (between edges) -> Out_valid drops immediately, Out_data=RST_VAL. Repeat with CLK_NEG=0 and RST_VAL=8'hA5: updates occur on posedge only, Out_data_n=5A after reset.
